// File: rtl/xadac_rr_arb.sv
// xadac_rr_arb: N-to-1 round-robin arbiter for one xadac request channel.
// Ports: clk, rstn, slv_* (N requesters), mst_* (selected channel + index).
module xadac_rr_arb #(
  parameter int unsigned NumReq     = 4,
  parameter type         DataT      = logic,
  parameter bit          LockPacket = 1'b1,
  parameter int unsigned IdxW       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  DataT              slv_data [NumReq],
  input  logic [NumReq-1:0] slv_last,
  input  logic [NumReq-1:0] slv_valid,
  output logic [NumReq-1:0] slv_ready,
  output DataT              mst_data,
  output logic              mst_last,
  output logic              mst_valid,
  input  logic              mst_ready,
  output logic [IdxW-1:0]   mst_idx
);

  typedef enum logic {
    FREE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t          lock_q;
  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] idx_q;

  logic [IdxW-1:0] w_free_sel;
  logic            w_found;
  logic [IdxW-1:0] w_sel;
  logic [IdxW-1:0] w_rr_nxt;
  logic            w_hs;
  logic            w_end;

  // Wrap at NumReq, which need not be a power of two.
  function automatic logic [IdxW-1:0] wrap_idx(
    input int unsigned base,
    input int unsigned off
  );
    int unsigned s;
    s = base + off;
    if (s >= NumReq) s = s - NumReq;
    return s[IdxW-1:0];
  endfunction

  // First valid requester starting at rr_q; rr_q itself if none.
  always_comb begin
    w_free_sel = rr_q;
    w_found    = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!w_found && slv_valid[wrap_idx(32'(rr_q), k)]) begin
        w_found    = 1'b1;
        w_free_sel = wrap_idx(32'(rr_q), k);
      end
    end
  end

  assign w_sel     = (lock_q == HELD) ? idx_q : w_free_sel;

  assign mst_valid = slv_valid[w_sel];
  assign mst_data  = slv_data[w_sel];
  assign mst_last  = slv_last[w_sel];
  assign mst_idx   = w_sel;

  always_comb begin
    slv_ready = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      slv_ready[i] = mst_ready && (w_sel == IdxW'(i));
    end
  end

  assign w_hs     = mst_valid && mst_ready;
  assign w_end    = w_hs && (LockPacket ? mst_last : 1'b1);
  assign w_rr_nxt = (w_sel == IdxW'(NumReq - 1)) ?
                    '0 : w_sel + IdxW'(1);

  // A stalled beat also takes the lock so the offer cannot change
  // until it is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_q <= FREE;
      rr_q   <= '0;
      idx_q  <= '0;
    end else if (w_end) begin
      lock_q <= FREE;
      rr_q   <= w_rr_nxt;
    end else if (w_hs || (mst_valid && !mst_ready)) begin
      lock_q <= HELD;
      idx_q  <= w_sel;
    end
  end

endmodule

// File: tb/tb_xadac_rr_arb.sv
// tb_xadac_rr_arb: random + directed checks of xadac_rr_arb against a model.
// Three instances: 4 req locked, 4 req unlocked, 3 req locked.
module tb_xadac_rr_arb;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rdy  = 1'b0;
  logic [3:0] sv   = '0;
  logic [3:0] sl   = '0;
  logic [7:0] sd   [4];
  logic [7:0] sd3  [3];

  logic [3:0] rdy_a, rdy_b;
  logic [2:0] rdy_c;
  logic [7:0] dat_a, dat_b, dat_c;
  logic       lst_a, lst_b, lst_c;
  logic       val_a, val_b, val_c;
  logic [1:0] idx_a, idx_b, idx_c;

  int n_vec = 0;
  int n_err = 0;

  int m_rr   [3];
  int m_lock [3];
  int m_idx  [3];
  int nreq   [3] = '{4, 4, 3};
  bit lkp    [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  assign sd3 = '{sd[0], sd[1], sd[2]};

  xadac_rr_arb #(
    .NumReq(4), .DataT(logic [7:0]), .LockPacket(1'b1)
  ) u_a (
    .clk(clk), .rstn(rstn),
    .slv_data(sd), .slv_last(sl), .slv_valid(sv),
    .slv_ready(rdy_a), .mst_data(dat_a), .mst_last(lst_a),
    .mst_valid(val_a), .mst_ready(rdy), .mst_idx(idx_a)
  );

  xadac_rr_arb #(
    .NumReq(4), .DataT(logic [7:0]), .LockPacket(1'b0)
  ) u_b (
    .clk(clk), .rstn(rstn),
    .slv_data(sd), .slv_last(sl), .slv_valid(sv),
    .slv_ready(rdy_b), .mst_data(dat_b), .mst_last(lst_b),
    .mst_valid(val_b), .mst_ready(rdy), .mst_idx(idx_b)
  );

  xadac_rr_arb #(
    .NumReq(3), .DataT(logic [7:0]), .LockPacket(1'b1)
  ) u_c (
    .clk(clk), .rstn(rstn),
    .slv_data(sd3), .slv_last(sl[2:0]), .slv_valid(sv[2:0]),
    .slv_ready(rdy_c), .mst_data(dat_c), .mst_last(lst_c),
    .mst_valid(val_c), .mst_ready(rdy), .mst_idx(idx_c)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: pick the first valid requester at or after the pointer,
  // unless a grant is currently held.
  function automatic int msel(input int d);
    if (m_lock[d] != 0) return m_idx[d];
    for (int k = 0; k < nreq[d]; k++) begin
      int j;
      j = (m_rr[d] + k) % nreq[d];
      if (sv[j]) return j;
    end
    return m_rr[d];
  endfunction

  function automatic void m_reset();
    for (int d = 0; d < 3; d++) begin
      m_rr[d]   = 0;
      m_lock[d] = 0;
      m_idx[d]  = 0;
    end
  endfunction

  function automatic void m_upd(input int d);
    int  s;
    bit  v, hs, fin;
    s   = msel(d);
    v   = sv[s];
    hs  = v && rdy;
    fin = hs && (lkp[d] ? sl[s] : 1'b1);
    if (fin) begin
      m_lock[d] = 0;
      m_rr[d]   = (s + 1) % nreq[d];
    end else if (v) begin
      m_lock[d] = 1;
      m_idx[d]  = s;
    end
  endfunction

  task automatic settle();
    #1;
    for (int d = 0; d < 3; d++) begin
      int         s;
      logic [1:0] ai;
      logic       av, al;
      logic [7:0] ad;
      logic [3:0] ar;
      s = msel(d);
      case (d)
        0:       begin ai = idx_a; av = val_a; al = lst_a;
                       ad = dat_a; ar = rdy_a; end
        1:       begin ai = idx_b; av = val_b; al = lst_b;
                       ad = dat_b; ar = rdy_b; end
        default: begin ai = idx_c; av = val_c; al = lst_c;
                       ad = dat_c; ar = {1'b0, rdy_c}; end
      endcase
      chk($sformatf("u%0d.idx", d), 32'(ai), 32'(s));
      chk($sformatf("u%0d.valid", d), 32'(av), 32'(sv[s]));
      chk($sformatf("u%0d.data", d), 32'(ad), 32'(sd[s]));
      chk($sformatf("u%0d.last", d), 32'(al), 32'(sl[s]));
      chk($sformatf("u%0d.ready", d), 32'(ar),
          rdy ? (32'd1 << s) : 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) for (int d = 0; d < 3; d++) m_upd(d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sv   = '0;
    rdy  = 1'b0;
    m_reset();
    settle();
    chk("rst.valid", 32'(val_a), 0);
    chk("rst.ready", 32'(rdy_a), 0);
    chk("rst.idx", 32'(idx_a), 0);
    tick();
    rstn = 1'b1;
  endtask

  int exp_l [4] = '{1, 1, 1, 3};
  int exp_n [4] = '{1, 3, 1, 3};

  initial begin
    for (int i = 0; i < 4; i++) sd[i] = 8'(8'h10 * (i + 1) + i);
    m_reset();
    @(negedge clk);

    // Reset state
    do_reset();
    settle();
    chk("idle.idx", 32'(idx_a), 0);
    tick();

    // Fairness: all valid, single-beat traffic
    do_reset();
    sv  = 4'b1111;
    sl  = 4'b1111;
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("fair.a", 32'(idx_a), 32'(i % 4));
      chk("fair.b", 32'(idx_b), 32'(i % 4));
      chk("fair.c", 32'(idx_c), 32'(i % 3));
      chk("fair.one", 32'($countones(rdy_b)), 1);
      tick();
    end

    // Stall: req2 offered, req0 joins mid-stall
    do_reset();
    sl    = 4'b1111;
    sd[2] = 8'hA5;
    sv    = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) sv = 4'b0101;
      settle();
      chk("stall.idx", 32'(idx_a), 2);
      chk("stall.data", 32'(dat_a), 32'h A5);
      chk("stall.idxb", 32'(idx_b), 2);
      tick();
    end
    rdy = 1'b1;
    settle();
    chk("stall.rdy", 32'(rdy_a), 32'b0100);
    tick();
    sv = 4'b0001;
    settle();
    chk("stall.next", 32'(idx_a), 0);
    chk("stall.nextc", 32'(idx_c), 0);
    tick();

    // Packet lock vs per-beat arbitration
    do_reset();
    sv  = 4'b1010;
    rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sl = {1'b1, 1'b0, (c == 2), 1'b0};
      settle();
      chk("pkt.lock", 32'(idx_a), 32'(exp_l[c]));
      chk("pkt.nolock", 32'(idx_b), 32'(exp_n[c]));
      tick();
    end

    // Async reset while held mid-packet on req2
    do_reset();
    sv  = 4'b0100;
    sl  = 4'b0000;
    rdy = 1'b1;
    settle();
    tick();
    settle();
    tick();
    sv = 4'b0110;
    settle();
    chk("held.idx", 32'(idx_a), 2);
    rstn = 1'b0;
    m_reset();
    #1;
    chk("arst.idx", 32'(idx_a), 1);
    chk("arst.idxc", 32'(idx_c), 1);
    tick();
    rstn = 1'b1;
    settle();
    chk("rel.idx", 32'(idx_a), 1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        sv  = 4'($urandom | $urandom);
        sl  = 4'($urandom);
        rdy = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) sd[i] = 8'($urandom);
        settle();
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
